// File: rtl/addr_bus_pkg.sv
// ---------------------------------------------------------------------------
// addr_bus_pkg
// Shared definitions for the addressable bus: the direction encoding used by
// the initiator and by every addressed target, the initiator state encoding,
// and helpers that decode which strobes a direction requires.
// No ports (package).
// ---------------------------------------------------------------------------
package addr_bus_pkg;

    // Direction of an addressed transaction; encoding 2'd3 is illegal.
    typedef enum logic [1:0] {
        DIR_READ         = 2'd0,
        DIR_WRITE        = 2'd1,
        DIR_READ_N_WRITE = 2'd2
    } addressed_direction_e;

    // Initiator FSM states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_DONE     = 2'd2
    } init_state_e;

    // Width of the optional WAIT_ACK timeout counter.
    localparam int TIMER_WIDTH = 16;

    function automatic logic dir_needs_read(input logic [1:0] dir);
        return (dir == DIR_READ) || (dir == DIR_READ_N_WRITE);
    endfunction

    function automatic logic dir_needs_write(input logic [1:0] dir);
        return (dir == DIR_WRITE) || (dir == DIR_READ_N_WRITE);
    endfunction

    function automatic logic dir_is_legal(input logic [1:0] dir);
        return dir != 2'd3;
    endfunction

endpackage

// File: rtl/addr_bus_timeout.sv
// ---------------------------------------------------------------------------
// addr_bus_timeout
// Cycle counter bounding how long the initiator waits for acknowledges.
// Only instantiated when ADDR_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   i_clear   in   hold the count at zero (initiator not waiting)
//   i_enable  in   count one cycle of waiting
//   o_expired out  count has reached TIMEOUT_CYCLES
// ---------------------------------------------------------------------------
module addr_bus_timeout
    import addr_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [TIMER_WIDTH-1:0] LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMER_WIDTH-1:0] r_count;

    // Count stops at the limit so it can never wrap back below it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/addr_bus_initiator.sv
// ---------------------------------------------------------------------------
// addr_bus_initiator
// Initiator end of the addressable bus. Accepts one command at a time on a
// valid/ready port, drives address and read/write strobes to the targets,
// collects their acknowledges and reports completion with a one-cycle done
// pulse plus an error status bit. All outputs are registered.
// Optional feature: define ADDR_BUS_TIMEOUT_EN to abort WAIT_ACK after
// TIMEOUT_CYCLES cycles with error=1.
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_addr, cmd_dir            target address and direction
//   active_address               address driven to targets
//   read_enable_in/write_enable_in   strobes to targets
//   read_enable_out/write_enable_out acknowledges from the addressed target
//   done, error                  completion pulse; error valid while done=1
// ---------------------------------------------------------------------------
module addr_bus_initiator
    import addr_bus_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [1:0]               cmd_dir,
    output logic [ADDRESS_WIDTH-1:0] active_address,
    output logic                     read_enable_in,
    output logic                     write_enable_in,
    input  logic                     read_enable_out,
    input  logic                     write_enable_out,
    output logic                     done,
    output logic                     error
);

    init_state_e              r_state;
    logic                     r_cmdReady;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [1:0]               r_dir;
    logic                     r_rdEn;
    logic                     r_wrEn;
    logic                     r_done;
    logic                     r_error;
    logic                     r_ackRd;
    logic                     r_ackWr;

    init_state_e              w_stateNext;
    logic                     w_readyNext;
    logic [ADDRESS_WIDTH-1:0] w_addrNext;
    logic [1:0]               w_dirNext;
    logic                     w_rdEnNext;
    logic                     w_wrEnNext;
    logic                     w_doneNext;
    logic                     w_errorNext;
    logic                     w_ackRdNext;
    logic                     w_ackWrNext;

    logic w_needRd;
    logic w_needWr;
    logic w_rdSeen;
    logic w_wrSeen;
    logic w_allAcked;
    logic w_expired;

    // Acks only count for the directions the latched command asked for; an
    // ack arriving this cycle is folded in so completion needs no extra cycle.
    assign w_needRd   = dir_needs_read(r_dir);
    assign w_needWr   = dir_needs_write(r_dir);
    assign w_rdSeen   = r_ackRd | (w_needRd & read_enable_out);
    assign w_wrSeen   = r_ackWr | (w_needWr & write_enable_out);
    assign w_allAcked = (~w_needRd | w_rdSeen) & (~w_needWr | w_wrSeen);

`ifdef ADDR_BUS_TIMEOUT_EN
    // Counter sits at zero outside WAIT_ACK, so it starts from zero on entry.
    addr_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (r_state != ST_WAIT_ACK),
        .i_enable  (r_state == ST_WAIT_ACK),
        .o_expired (w_expired)
    );
`else
    // Without the timeout, WAIT_ACK waits indefinitely. The range test keeps
    // TIMEOUT_CYCLES referenced so both builds share one parameter list.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_timeoutRangeBad
    end
    assign w_expired = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cmdReady <= 1'b1;
            r_addr     <= '0;
            r_dir      <= 2'd0;
            r_rdEn     <= 1'b0;
            r_wrEn     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_ackRd    <= 1'b0;
            r_ackWr    <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_cmdReady <= w_readyNext;
            r_addr     <= w_addrNext;
            r_dir      <= w_dirNext;
            r_rdEn     <= w_rdEnNext;
            r_wrEn     <= w_wrEnNext;
            r_done     <= w_doneNext;
            r_error    <= w_errorNext;
            r_ackRd    <= w_ackRdNext;
            r_ackWr    <= w_ackWrNext;
        end
    end

    // Next state and next output values. DONE behaves like IDLE for
    // acceptance because cmd_ready is already high during the done pulse, so
    // a handshake in that cycle must not be dropped.
    always_comb begin
        w_stateNext = r_state;
        w_readyNext = r_cmdReady;
        w_addrNext  = r_addr;
        w_dirNext   = r_dir;
        w_rdEnNext  = r_rdEn;
        w_wrEnNext  = r_wrEn;
        w_doneNext  = 1'b0;
        w_errorNext = 1'b0;
        w_ackRdNext = r_ackRd;
        w_ackWrNext = r_ackWr;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_stateNext = ST_IDLE;
                w_readyNext = 1'b1;
                if (cmd_valid && r_cmdReady) begin
                    if (dir_is_legal(cmd_dir)) begin
                        w_stateNext = ST_WAIT_ACK;
                        w_readyNext = 1'b0;
                        w_addrNext  = cmd_addr;
                        w_dirNext   = cmd_dir;
                        w_rdEnNext  = dir_needs_read(cmd_dir);
                        w_wrEnNext  = dir_needs_write(cmd_dir);
                        w_ackRdNext = 1'b0;
                        w_ackWrNext = 1'b0;
                    end else begin
                        // Illegal direction: report immediately, bus untouched.
                        w_stateNext = ST_DONE;
                        w_doneNext  = 1'b1;
                        w_errorNext = 1'b1;
                    end
                end
            end

            ST_WAIT_ACK: begin
                w_readyNext = 1'b0;
                w_ackRdNext = w_rdSeen;
                w_ackWrNext = w_wrSeen;
                // A complete ack set wins over a timeout in the same cycle.
                if (w_allAcked || w_expired) begin
                    w_stateNext = ST_DONE;
                    w_readyNext = 1'b1;
                    w_rdEnNext  = 1'b0;
                    w_wrEnNext  = 1'b0;
                    w_doneNext  = 1'b1;
                    w_errorNext = ~w_allAcked;
                    w_ackRdNext = 1'b0;
                    w_ackWrNext = 1'b0;
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_readyNext = 1'b1;
                w_rdEnNext  = 1'b0;
                w_wrEnNext  = 1'b0;
            end
        endcase
    end

    assign cmd_ready       = r_cmdReady;
    assign active_address  = r_addr;
    assign read_enable_in  = r_rdEn;
    assign write_enable_in = r_wrEn;
    assign done            = r_done;
    assign error           = r_error;

endmodule

// File: tb/tb_addr_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_addr_bus_initiator
// Table-driven check of addr_bus_initiator: each record holds the inputs for
// one cycle and the outputs expected in the following cycle. A hand-written
// sequence covers reset in the middle of a transaction.
// ---------------------------------------------------------------------------
module tb_addr_bus_initiator;
    import addr_bus_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_addr;
    logic [1:0] cmd_dir;
    logic [3:0] active_address;
    logic       read_enable_in;
    logic       write_enable_in;
    logic       read_enable_out;
    logic       write_enable_out;
    logic       done;
    logic       error;

    // Expected output word: {ready, addr[3:0], rdEn, wrEn, done, error}.
    typedef struct {
        string      name;
        logic       valid;
        logic [3:0] addr;
        logic [1:0] dir;
        logic       rdAck;
        logic       wrAck;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   numCompared;
    int   numMismatched;

    addr_bus_initiator #(
        .ADDRESS_WIDTH  (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_addr         (cmd_addr),
        .cmd_dir          (cmd_dir),
        .active_address   (active_address),
        .read_enable_in   (read_enable_in),
        .write_enable_in  (write_enable_in),
        .read_enable_out  (read_enable_out),
        .write_enable_out (write_enable_out),
        .done             (done),
        .error            (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] expOut(input logic rdy, input logic [3:0] a,
                                          input logic rd, input logic wr,
                                          input logic dn, input logic er);
        return {rdy, a, rd, wr, dn, er};
    endfunction

    task automatic addVec(input string n, input logic v, input logic [3:0] a,
                          input logic [1:0] d, input logic ra, input logic wa,
                          input logic [8:0] e);
        vec_t t;
        t.name = n; t.valid = v; t.addr = a; t.dir = d;
        t.rdAck = ra; t.wrAck = wa; t.exp = e;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t);
        @(negedge clk);
        cmd_valid        = t.valid;
        cmd_addr         = t.addr;
        cmd_dir          = t.dir;
        read_enable_out  = t.rdAck;
        write_enable_out = t.wrAck;
    endtask

    task automatic checkOutput(input string n, input logic [8:0] e);
        logic [8:0] act;
        act = {cmd_ready, active_address, read_enable_in, write_enable_in, done, error};
        numCompared++;
        if (act !== e) begin
            numMismatched++;
            $display("[TB] FAIL %s: got rdy/addr/rd/wr/done/err=%b_%h_%b%b_%b%b, expected %b_%h_%b%b_%b%b",
                     n, act[8], act[7:4], act[3], act[2], act[1], act[0],
                     e[8], e[7:4], e[3], e[2], e[1], e[0]);
        end
    endtask

    task automatic idleInputs();
        cmd_valid        = 1'b0;
        cmd_addr         = 4'd0;
        cmd_dir          = 2'd0;
        read_enable_out  = 1'b0;
        write_enable_out = 1'b0;
    endtask

    initial begin
        numCompared   = 0;
        numMismatched = 0;
        rst_n = 1'b0;
        idleInputs();

        // Reset state, sampled while reset is still asserted.
        repeat (2) @(posedge clk);
        #1 checkOutput("resetState", expOut(1, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Idle, and stray acks in idle are ignored.
        addVec("idle0",   0, 0, 0, 0, 0, expOut(1, 0, 0, 0, 0, 0));
        addVec("idleAck", 0, 0, 0, 1, 1, expOut(1, 0, 0, 0, 0, 0));

        // READ addr 5, ack in the first strobe cycle: done at accept+2.
        addVec("rd5Acc",  1, 5, DIR_READ, 0, 0, expOut(0, 5, 1, 0, 0, 0));
        addVec("rd5Ack",  0, 0, 0, 1, 0,        expOut(1, 5, 0, 0, 1, 0));
        addVec("rd5Post", 0, 0, 0, 0, 1,        expOut(1, 5, 0, 0, 0, 0));

        // READ_N_WRITE addr 9, write ack at +2, read ack at +4: done at +5.
        addVec("rnw9Acc", 1, 9, DIR_READ_N_WRITE, 0, 0, expOut(0, 9, 1, 1, 0, 0));
        addVec("rnw9P1",  0, 0, 0, 0, 0, expOut(0, 9, 1, 1, 0, 0));
        addVec("rnw9Wr",  0, 0, 0, 0, 1, expOut(0, 9, 1, 1, 0, 0));
        addVec("rnw9P3",  0, 0, 0, 0, 0, expOut(0, 9, 1, 1, 0, 0));
        addVec("rnw9Rd",  0, 0, 0, 1, 0, expOut(1, 9, 0, 0, 1, 0));
        addVec("rnw9Post",0, 0, 0, 0, 0, expOut(1, 9, 0, 0, 0, 0));

        // Illegal direction at addr 7: no strobe, address unchanged, error.
        addVec("ill7",    1, 7, 2'd3, 0, 0, expOut(1, 9, 0, 0, 1, 1));
        addVec("ill7Post",0, 0, 0, 0, 0,    expOut(1, 9, 0, 0, 0, 0));

        // WRITE addr 3, stray read ack at +1, write ack at +3: done at +4.
        addVec("wr3Acc",  1, 3, DIR_WRITE, 0, 0, expOut(0, 3, 0, 1, 0, 0));
        addVec("wr3Stray",0, 0, 0, 1, 0, expOut(0, 3, 0, 1, 0, 0));
        addVec("wr3P2",   0, 0, 0, 0, 0, expOut(0, 3, 0, 1, 0, 0));
        addVec("wr3Ack",  0, 0, 0, 0, 1, expOut(1, 3, 0, 0, 1, 0));
        addVec("wr3Post", 0, 0, 0, 0, 0, expOut(1, 3, 0, 0, 0, 0));

        // READ_N_WRITE to the top address with both acks together, then a
        // READ to address 0 accepted in the cycle right after done.
        addVec("rnwFAcc", 1, 15, DIR_READ_N_WRITE, 0, 0, expOut(0, 15, 1, 1, 0, 0));
        addVec("rnwFAck", 0, 0, 0, 1, 1,   expOut(1, 15, 0, 0, 1, 0));
        addVec("rd0Acc",  1, 0, DIR_READ, 0, 0, expOut(0, 0, 1, 0, 0, 0));
        addVec("rd0Ack",  0, 0, 0, 1, 0,   expOut(1, 0, 0, 0, 1, 0));
        addVec("rd0Post", 0, 0, 0, 0, 0,   expOut(1, 0, 0, 0, 0, 0));

`ifdef ADDR_BUS_TIMEOUT_EN
        // READ never acknowledged: abort with error at accept+6.
        addVec("toAcc",   1, 4, DIR_READ, 0, 0, expOut(0, 4, 1, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            addVec($sformatf("toWait%0d", k), 0, 0, 0, 0, 0, expOut(0, 4, 1, 0, 0, 0));
        addVec("toExpire",0, 0, 0, 0, 0, expOut(1, 4, 0, 0, 1, 1));
        addVec("toPost",  0, 0, 0, 0, 0, expOut(1, 4, 0, 0, 0, 0));
        // Ack on the fourth WAIT_ACK cycle completes normally.
        addVec("to4Acc",  1, 6, DIR_READ, 0, 0, expOut(0, 6, 1, 0, 0, 0));
        for (int k = 1; k <= 3; k++)
            addVec($sformatf("to4Wait%0d", k), 0, 0, 0, 0, 0, expOut(0, 6, 1, 0, 0, 0));
        addVec("to4Ack",  0, 0, 0, 1, 0, expOut(1, 6, 0, 0, 1, 0));
        addVec("to4Post", 0, 0, 0, 0, 0, expOut(1, 6, 0, 0, 0, 0));
        // Ack in the very cycle the count reaches the limit still succeeds.
        addVec("to5Acc",  1, 8, DIR_READ, 0, 0, expOut(0, 8, 1, 0, 0, 0));
        for (int k = 1; k <= 4; k++)
            addVec($sformatf("to5Wait%0d", k), 0, 0, 0, 0, 0, expOut(0, 8, 1, 0, 0, 0));
        addVec("to5Ack",  0, 0, 0, 1, 0, expOut(1, 8, 0, 0, 1, 0));
        addVec("to5Post", 0, 0, 0, 0, 0, expOut(1, 8, 0, 0, 0, 0));
`else
        // Without the timeout a long unacknowledged WRITE keeps waiting.
        addVec("longAcc", 1, 12, DIR_WRITE, 0, 0, expOut(0, 12, 0, 1, 0, 0));
        for (int k = 1; k <= 20; k++)
            addVec($sformatf("longWait%0d", k), 0, 0, 0, 0, 0, expOut(0, 12, 0, 1, 0, 0));
        addVec("longAck", 0, 0, 0, 0, 1, expOut(1, 12, 0, 0, 1, 0));
        addVec("longPost",0, 0, 0, 0, 0, expOut(1, 12, 0, 0, 0, 0));
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1 checkOutput(vecs[i].name, vecs[i].exp);
        end

        // Reset while waiting for an ack: strobes drop at once, no done.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 4'd2; cmd_dir = DIR_WRITE;
        @(posedge clk);
        #1 checkOutput("rstMidAcc", expOut(0, 2, 0, 1, 0, 0));
        @(negedge clk);
        idleInputs();
        rst_n = 1'b0;
        #1 checkOutput("rstMidAsync", expOut(1, 0, 0, 0, 0, 0));
        write_enable_out = 1'b1;
        @(posedge clk);
        #1 checkOutput("rstMidHold", expOut(1, 0, 0, 0, 0, 0));
        @(negedge clk);
        write_enable_out = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 checkOutput("rstRelease", expOut(1, 0, 0, 0, 0, 0));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_addr = 4'd6; cmd_dir = DIR_WRITE;
        @(posedge clk);
        #1 checkOutput("postRstAcc", expOut(0, 6, 0, 1, 0, 0));
        @(negedge clk);
        idleInputs();
        write_enable_out = 1'b1;
        @(posedge clk);
        #1 checkOutput("postRstDone", expOut(1, 6, 0, 0, 1, 0));
        @(negedge clk);
        idleInputs();
        @(posedge clk);
        #1 checkOutput("postRstIdle", expOut(1, 6, 0, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
